// File: rtl/cmult_pipe6_pkg.sv
// Shared widths, rounding and saturation constants for the cmult_pipe6 complex multiplier.
// satClip clamps a post-shift sum into the signed DATA_W output range.
package cmult_pipe6_pkg;

  localparam int DATA_W        = 25;
  localparam int TW_W          = 16;
  localparam int CMULT_LATENCY = 6;
  localparam int PROD_W        = DATA_W + TW_W;
  localparam int SUM_W         = PROD_W + 1;
  localparam int SHIFT         = TW_W - 1;

  localparam logic signed [SUM_W-1:0] ROUND_K = SUM_W'(2 ** (TW_W - 2));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (DATA_W - 1)));

  typedef struct packed {
    logic                     sat;
    logic signed [DATA_W-1:0] val;
  } sat_res_t;

  function automatic sat_res_t satClip(input logic signed [SUM_W-1:0] v);
    sat_res_t res;
    if (v > SAT_MAX) begin
      res.sat = 1'b1;
      res.val = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      res.sat = 1'b1;
      res.val = SAT_MIN[DATA_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.val = v[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cmult_pipe6_if.sv
// Streaming bus of the complex multiplier: enable, input sample/twiddle, output product.
interface cmult_pipe6_if;
  import cmult_pipe6_pkg::*;

  logic                     en;
  logic                     in_valid;
  logic signed [DATA_W-1:0] a_re;
  logic signed [DATA_W-1:0] a_im;
  logic signed [TW_W-1:0]   w_re;
  logic signed [TW_W-1:0]   w_im;
  logic                     out_valid;
  logic signed [DATA_W-1:0] p_re;
  logic signed [DATA_W-1:0] p_im;
  logic                     sat;

  modport master (
    output en, in_valid, a_re, a_im, w_re, w_im,
    input  out_valid, p_re, p_im, sat
  );

  modport slave (
    input  en, in_valid, a_re, a_im, w_re, w_im,
    output out_valid, p_re, p_im, sat
  );

endinterface

// File: rtl/cmult_pipe6_round_shift_sat.sv
// Last two pipeline stages of one product component: add the half-LSB rounding
// constant, then floor-shift back to data scale and clamp, flagging any clamp.
module round_shift_sat
  import cmult_pipe6_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_en,
  input  logic signed [SUM_W-1:0]  i_sum,
  output logic signed [DATA_W-1:0] o_p,
  output logic                     o_sat
);

  logic signed [SUM_W-1:0]  r_rnd;
  logic signed [DATA_W-1:0] r_p;
  logic                     r_sat;
  logic signed [SUM_W-1:0]  w_shift;
  sat_res_t                 w_clip;

  assign w_shift = r_rnd >>> SHIFT;
  assign w_clip  = satClip(w_shift);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rnd <= '0;
      r_p   <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_rnd <= i_sum + ROUND_K;
      r_p   <= w_clip.val;
      r_sat <= w_clip.sat;
    end
  end

  assign o_p   = r_p;
  assign o_sat = r_sat;

endmodule

// File: rtl/cmult_pipe6.sv
// Six-stage pipelined signed complex multiplier p = a * w with Q1.15 twiddle,
// global enable stall and a valid bit that travels alongside the data.
module cmult_pipe6
  import cmult_pipe6_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  cmult_pipe6_if.slave  bus
);

  logic signed [DATA_W-1:0] r1_a_re, r1_a_im;
  logic signed [TW_W-1:0]   r1_w_re, r1_w_im;
  logic signed [PROD_W-1:0] r2_rr, r2_ii, r2_ri, r2_ir;
  logic signed [PROD_W-1:0] r3_rr, r3_ii, r3_ri, r3_ir;
  logic signed [SUM_W-1:0]  r4_re, r4_im;
  logic [CMULT_LATENCY-1:0] r_valid;

  logic signed [PROD_W-1:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [DATA_W-1:0] w_p_re, w_p_im;
  logic                     w_sat_re, w_sat_im;

  // Operands widened to PROD_W so the multiply keeps full precision, including (-1)*(-1).
  assign w_rr = PROD_W'(r1_a_re) * PROD_W'(r1_w_re);
  assign w_ii = PROD_W'(r1_a_im) * PROD_W'(r1_w_im);
  assign w_ri = PROD_W'(r1_a_re) * PROD_W'(r1_w_im);
  assign w_ir = PROD_W'(r1_a_im) * PROD_W'(r1_w_re);

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_a_re <= '0;
      r1_a_im <= '0;
      r1_w_re <= '0;
      r1_w_im <= '0;
      r2_rr   <= '0;
      r2_ii   <= '0;
      r2_ri   <= '0;
      r2_ir   <= '0;
      r3_rr   <= '0;
      r3_ii   <= '0;
      r3_ri   <= '0;
      r3_ir   <= '0;
      r4_re   <= '0;
      r4_im   <= '0;
      r_valid <= '0;
    end else if (bus.en) begin
      r1_a_re <= bus.a_re;
      r1_a_im <= bus.a_im;
      r1_w_re <= bus.w_re;
      r1_w_im <= bus.w_im;
      r2_rr   <= w_rr;
      r2_ii   <= w_ii;
      r2_ri   <= w_ri;
      r2_ir   <= w_ir;
      r3_rr   <= r2_rr;
      r3_ii   <= r2_ii;
      r3_ri   <= r2_ri;
      r3_ir   <= r2_ir;
      r4_re   <= SUM_W'(r3_rr) - SUM_W'(r3_ii);
      r4_im   <= SUM_W'(r3_ri) + SUM_W'(r3_ir);
      r_valid <= {r_valid[CMULT_LATENCY-2:0], bus.in_valid};
    end
  end

  round_shift_sat u_rss_re (
    .clk   (clk),
    .reset (reset),
    .i_en  (bus.en),
    .i_sum (r4_re),
    .o_p   (w_p_re),
    .o_sat (w_sat_re)
  );

  round_shift_sat u_rss_im (
    .clk   (clk),
    .reset (reset),
    .i_en  (bus.en),
    .i_sum (r4_im),
    .o_p   (w_p_im),
    .o_sat (w_sat_im)
  );

  assign bus.out_valid = r_valid[CMULT_LATENCY-1];
  assign bus.p_re      = w_p_re;
  assign bus.p_im      = w_p_im;
  assign bus.sat       = w_sat_re | w_sat_im;

endmodule
